// File: rtl/cpu_clk_ctrl.sv
// rtl/cpu_clk_ctrl.sv - CPU clock-enable generator (run/step/halt), LED register and enable counter
// The core stays on the system clock and advances only on single-cycle cpu_ce_o pulses.
module cpu_clk_ctrl #(
  parameter int          DIV_W      = 24,
  parameter int          LED_N      = 4,
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter bit          LED_INV    = 1'b0,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             step_btn_i,
  input  logic [LED_N-1:0] led_i,
  output logic             cpu_ce_o,
  output logic [LED_N-1:0] led_o,
  output logic [CNT_W-1:0] ce_cnt_o,
  output logic [1:0]       mode_o
);

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_STEP = 2'b01,
    MODE_HALT = 2'b10
  } mode_t;

  localparam logic [15:0] DEB_LAST = (DEB_CYCLES == 16'd0) ? 16'd0 : DEB_CYCLES - 16'd1;

  mode_t            mode_q;
  mode_t            mode_nxt;
  logic [DIV_W-1:0] cnt;
  logic             sync1;
  logic             sync2;
  logic             btn_stable;
  logic [15:0]      deb_cnt;
  logic             step_edge;
  logic             ce_d;
  logic             mode_chg;
  logic             run_hit;
  logic             deb_accept;
  logic             fire;

  always_comb begin
    mode_nxt = MODE_HALT;
    if (mode_i != 2'b11) mode_nxt = mode_t'(mode_i);
  end

  assign mode_chg   = (mode_nxt != mode_q);
  // >= rather than == so lowering div_i below cnt fires at once instead of wrapping
  assign run_hit    = (cnt >= div_i);
  assign deb_accept = (sync2 != btn_stable) && (deb_cnt == DEB_LAST);
  // Decision uses the registered mode, so the old mode's enable still fires on a change
  assign fire       = ((mode_q == MODE_RUN) && run_hit) || ((mode_q == MODE_STEP) && step_edge);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= MODE_HALT;
      cnt        <= '0;
      cpu_ce_o   <= 1'b0;
      ce_cnt_o   <= '0;
      ce_d       <= 1'b0;
      led_o      <= {LED_N{LED_INV}};
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      btn_stable <= 1'b0;
      deb_cnt    <= '0;
      step_edge  <= 1'b0;
    end else begin
      mode_q   <= mode_nxt;
      cpu_ce_o <= fire;
      if (fire) ce_cnt_o <= ce_cnt_o + CNT_W'(1);

      if (mode_chg || (mode_q != MODE_RUN) || run_hit) cnt <= '0;
      else                                             cnt <= cnt + DIV_W'(1);

      sync1 <= step_btn_i;
      sync2 <= sync1;
      if (sync2 == btn_stable) begin
        deb_cnt <= '0;
      end else if (deb_accept) begin
        deb_cnt    <= '0;
        btn_stable <= sync2;
      end else begin
        deb_cnt <= deb_cnt + 16'd1;
      end
      // A rising edge accepted in the same clock as a mode change is dropped
      step_edge <= deb_accept && sync2 && !mode_chg;

      // Core outputs settle on the edge that samples ce, so capture one clock later
      ce_d <= cpu_ce_o;
      if (ce_d) led_o <= led_i ^ {LED_N{LED_INV}};
    end
  end

  assign mode_o = mode_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb/tb_cpu_clk_ctrl.sv - self-checking bench for cpu_clk_ctrl with a behavioural reference model
module tb_cpu_clk_ctrl;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode_i = 2'b00;
  logic [23:0] div_i = 24'd1;
  logic        step_btn = 1'b0;
  logic [3:0]  led_i = 4'b0000;

  logic        a_ce, b_ce;
  logic [3:0]  a_led, b_led;
  logic [31:0] a_cnt;
  logic [3:0]  b_cnt;
  logic [1:0]  a_mode, b_mode;

  int vecs = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(.DIV_W(24), .LED_N(4), .DEB_CYCLES(16'd4), .LED_INV(1'b0), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .mode_i(mode_i), .div_i(div_i), .step_btn_i(step_btn), .led_i(led_i),
    .cpu_ce_o(a_ce), .led_o(a_led), .ce_cnt_o(a_cnt), .mode_o(a_mode));

  cpu_clk_ctrl #(.DIV_W(24), .LED_N(4), .DEB_CYCLES(16'd4), .LED_INV(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .mode_i(mode_i), .div_i(div_i), .step_btn_i(step_btn), .led_i(led_i),
    .cpu_ce_o(b_ce), .led_o(b_led), .ce_cnt_o(b_cnt), .mode_o(b_mode));

  // Reference model: clocks elapsed since the last enable, and a raw-button history window
  logic [1:0]  m_mode = 2'b10;
  int          m_cnt = 0;
  logic        m_ce = 1'b0;
  logic        m_ce_d = 1'b0;
  logic [31:0] m_cecnt = 32'd0;
  logic [3:0]  m_led = 4'b0000;
  logic [15:0] m_raw = 16'd0;
  logic        m_stable = 1'b0;
  logic        m_pend = 1'b0;

  function automatic logic [1:0] eff_mode(input logic [1:0] m);
    return (m == 2'b11) ? 2'b10 : m;
  endfunction

  wire m_chg  = (eff_mode(mode_i) != m_mode);
  wire m_fire = ((m_mode == 2'b00) && (m_cnt >= int'(div_i))) || ((m_mode == 2'b01) && m_pend);
  // The button level seen two clocks late has disagreed with the stable level for DEB clocks
  wire m_flip = (m_raw[DEB:1] == {DEB{~m_stable}});

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode <= 2'b10; m_cnt <= 0; m_ce <= 1'b0; m_ce_d <= 1'b0; m_cecnt <= 32'd0;
      m_led <= 4'b0000; m_raw <= 16'd0; m_stable <= 1'b0; m_pend <= 1'b0;
    end else begin
      m_mode  <= eff_mode(mode_i);
      m_ce    <= m_fire;
      m_cnt   <= (m_chg || (m_mode != 2'b00) || m_fire) ? 0 : m_cnt + 1;
      m_cecnt <= m_cecnt + 32'(m_fire);
      m_ce_d  <= m_ce;
      if (m_ce_d) m_led <= led_i;
      m_raw   <= {m_raw[14:0], step_btn};
      if (m_flip) m_stable <= ~m_stable;
      m_pend  <= m_flip && !m_stable && !m_chg;
    end
  end

  wire [49:0] obs = {a_ce, a_mode, a_cnt, a_led, b_ce, b_mode, b_cnt, b_led};

  function automatic logic [49:0] exp_all();
    return {m_ce, m_mode, m_cecnt, m_led, m_ce, m_mode, m_cecnt[3:0], ~m_led};
  endfunction

  task automatic test_reset();
    logic exp_ce;
    rst = 1'b0; mode_i = 2'b00; div_i = 24'd1; step_btn = 1'b0; led_i = 4'b1010;
    repeat (3) begin
      @(negedge clk);
      vecs++;
      if ({a_ce, a_mode, a_cnt, a_led} !== {1'b0, 2'b10, 32'd0, 4'b0000}) begin
        fails++; $display("FAIL reset_a: got %h want %h", {a_ce, a_mode, a_cnt, a_led}, {1'b0, 2'b10, 32'd0, 4'b0000});
      end
      vecs++;
      if ({b_ce, b_mode, b_cnt, b_led} !== {1'b0, 2'b10, 4'd0, 4'b1111}) begin
        fails++; $display("FAIL reset_b: got %h want %h", {b_ce, b_mode, b_cnt, b_led}, {1'b0, 2'b10, 4'd0, 4'b1111});
      end
    end
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      exp_ce = (i == 3);
      vecs++;
      if ({a_mode, a_ce} !== {2'b00, exp_ce}) begin
        fails++; $display("FAIL first_pulse clk%0d: got mode=%b ce=%b want mode=00 ce=%b", i, a_mode, a_ce, exp_ce);
      end
      vecs++;
      if (obs !== exp_all()) begin fails++; $display("FAIL model_reset: got %h want %h", obs, exp_all()); end
    end
  endtask

  task automatic test_run_div();
    int found = 0;
    int pulses = 0;
    int last = 0;
    div_i = 24'd3;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      vecs++;
      if (obs !== exp_all()) begin fails++; $display("FAIL model_run_sync: got %h want %h", obs, exp_all()); end
      if (a_ce) found = 1;
    end
    vecs++;
    if (found != 1) begin fails++; $display("FAIL run_sync_timeout: got no pulse in 10 clocks, want a pulse"); end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      vecs++;
      if (obs !== exp_all()) begin fails++; $display("FAIL model_run: got %h want %h", obs, exp_all()); end
      if (a_ce) begin
        pulses++;
        vecs++;
        if (i - last != 4) begin fails++; $display("FAIL run_spacing: got gap %0d want 4", i - last); end
        last = i;
      end
    end
    vecs++;
    if (pulses != 10) begin fails++; $display("FAIL run_count: got %0d pulses want 10", pulses); end
    repeat (2) @(negedge clk);
    div_i = 24'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (a_ce !== 1'b1) begin fails++; $display("FAIL div_lowered clk%0d: got ce=%b want 1", i, a_ce); end
      vecs++;
      if (obs !== exp_all()) begin fails++; $display("FAIL model_div_lowered: got %h want %h", obs, exp_all()); end
    end
  endtask

  task automatic test_led();
    logic prev_ce = 1'b0;
    mode_i = 2'b00; div_i = 24'd2; led_i = 4'b0110;
    repeat (8) begin
      @(negedge clk);
      vecs++;
      if (obs !== exp_all()) begin fails++; $display("FAIL model_led_warm: got %h want %h", obs, exp_all()); end
    end
    repeat (30) begin
      @(negedge clk);
      vecs++;
      if ({a_led, b_led} !== {4'b0110, 4'b1001}) begin
        fails++; $display("FAIL led_hold: got a=%b b=%b want a=0110 b=1001", a_led, b_led);
      end
      vecs++;
      if (obs !== exp_all()) begin fails++; $display("FAIL model_led: got %h want %h", obs, exp_all()); end
      led_i = prev_ce ? 4'b0110 : 4'($urandom);
      prev_ce = a_ce;
    end
  endtask

  task automatic test_step();
    int pulses = 0;
    logic exp_ce;
    mode_i = 2'b01; step_btn = 1'b0;
    repeat (4) @(negedge clk);
    step_btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) step_btn = 1'b0;
      vecs++;
      if (a_ce !== 1'b0) begin fails++; $display("FAIL step_glitch clk%0d: got ce=%b want 0", i, a_ce); end
      vecs++;
      if (obs !== exp_all()) begin fails++; $display("FAIL model_glitch: got %h want %h", obs, exp_all()); end
    end
    step_btn = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      exp_ce = (i == 2 + DEB + 1);
      vecs++;
      if (a_ce !== exp_ce) begin fails++; $display("FAIL step_press clk%0d: got ce=%b want %b", i, a_ce, exp_ce); end
      vecs++;
      if (obs !== exp_all()) begin fails++; $display("FAIL model_press: got %h want %h", obs, exp_all()); end
    end
    step_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vecs++;
      if (a_ce !== 1'b0) begin fails++; $display("FAIL step_release clk%0d: got ce=%b want 0", i, a_ce); end
    end
    step_btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_ce) pulses++;
      vecs++;
      if (obs !== exp_all()) begin fails++; $display("FAIL model_repress: got %h want %h", obs, exp_all()); end
    end
    vecs++;
    if (pulses != 1) begin fails++; $display("FAIL step_repress: got %0d pulses want 1", pulses); end
  endtask

  task automatic test_halt();
    logic [31:0] base;
    mode_i = 2'b10; div_i = 24'd0;
    repeat (2) begin
      @(negedge clk);
      vecs++;
      if (obs !== exp_all()) begin fails++; $display("FAIL model_halt_entry: got %h want %h", obs, exp_all()); end
    end
    base = m_cecnt;
    for (int i = 0; i < 100; i++) begin
      mode_i = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
      if ((i % 9) == 0) step_btn = ~step_btn;
      @(negedge clk);
      vecs++;
      if ({a_ce, a_mode, a_cnt} !== {1'b0, 2'b10, base}) begin
        fails++; $display("FAIL halt clk%0d: got ce=%b mode=%b cnt=%0d want 0/10/%0d", i, a_ce, a_mode, a_cnt, base);
      end
    end
    step_btn = 1'b0;
  endtask

  task automatic test_wrap();
    logic seen = 1'b0;
    logic [3:0] prev_b = 4'd0;
    mode_i = 2'b00; div_i = 24'd0;
    repeat (40) begin
      @(negedge clk);
      vecs++;
      if (obs !== exp_all()) begin fails++; $display("FAIL model_wrap: got %h want %h", obs, exp_all()); end
      if (prev_b == 4'd15 && b_cnt == 4'd0) seen = 1'b1;
      prev_b = b_cnt;
    end
    vecs++;
    if (seen !== 1'b1) begin fails++; $display("FAIL cnt_wrap: got no 15->0 step, want one"); end
  endtask

  task automatic test_async_reset();
    int found = 0;
    mode_i = 2'b00; div_i = 24'd1;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (a_ce) found = 1;
    end
    vecs++;
    if (found != 1) begin fails++; $display("FAIL async_sync_timeout: got no pulse in 10 clocks, want a pulse"); end
    #2 rst = 1'b0;
    #1;
    vecs++;
    if ({a_ce, b_ce, a_mode, a_cnt, b_led} !== {1'b0, 1'b0, 2'b10, 32'd0, 4'b1111}) begin
      fails++; $display("FAIL async_reset: got ce=%b%b mode=%b cnt=%0d bled=%b want 00/10/0/1111", a_ce, b_ce, a_mode, a_cnt, b_led);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      vecs++;
      if (obs !== exp_all()) begin fails++; $display("FAIL model_after_reset: got %h want %h", obs, exp_all()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      vecs++;
      if (obs !== exp_all()) begin fails++; $display("FAIL model_random cyc%0d: got %h want %h", i, obs, exp_all()); end
      if ($urandom_range(0, 15) == 0) mode_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  div_i = 24'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0)  step_btn = ~step_btn;
      led_i = 4'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_run_div();
    test_led();
    test_step();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Parametrised successor to the fixed clock-delay and LED pass-through logic of the minimal SOPC top.
- Produces a single-cycle clock-enable for the pipeline CPU, so the core runs on the system clock with no derived clock.
- Three modes: free-run at a programmable divide ratio, single-step from a debounced push-button, and halt.
- Registers N LED channels from the core (optional inversion) and counts issued enables for debug.

Parameters:
DIV_W, 24, width of divide-ratio input and internal divider counter
LED_N, 4, number of LED channels
DEB_CYCLES, 16'd50000, system clocks the step button must be stable before an edge is accepted
LED_INV, 0, 1 = LEDs active-low (led_o driven inverted)
CNT_W, 32, width of enable counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset)
mode_i  in  2  00 run, 01 step, 10 halt, 11 treated as halt
div_i  in  DIV_W  run-mode ratio: enable every div_i+1 clocks
step_btn_i  in  1  raw asynchronous push-button, active-high
led_i  in  LED_N  LED bits from core
cpu_ce_o  out  1  one-cycle clock-enable to core
led_o  out  LED_N  registered LED drive
ce_cnt_o  out  CNT_W  number of cpu_ce_o pulses since reset
mode_o  out  2  registered effective mode: 00 run, 01 step, 10 halt

Behaviour:
Reset (rst=0, async):
- cnt=0; cpu_ce_o=0; ce_cnt_o=0; mode_o=10 (halt).
- led_o = all 0 if LED_INV=0, else all 1.
- Synchroniser, debounce counter and stable-button register all cleared.
- Operation resumes on the first clk edge after rst=1.

Mode register:
- mode_o <= mode_i each clock; 11 maps to 10.
- On any change of mode_o: divider cnt <= 0 and any pending step edge is discarded.
- The enable decision uses mode_o, so a mode change takes effect one clock later.

States (mode_o):
- RUN:
  - cnt increments each clock.
  - When cnt >= div_i: cpu_ce_o=1 for that clock and cnt <= 0.
  - div_i=0 gives an enable every clock.
  - If div_i is lowered below the current cnt, the enable fires on the next clock (>= compare), with no wrap through 2^DIV_W.
- STEP:
  - cnt held 0.
  - Each accepted rising edge of the debounced button produces exactly one cpu_ce_o pulse, registered one clock after the edge is accepted.
  - Holding the button gives no further pulses.
- HALT: cpu_ce_o=0; cnt held 0.

Button debounce:
- 2-FF synchroniser, then the stable register updates only after the synchronised level differs from it for DEB_CYCLES consecutive clocks.
- The differ-counter clears when the levels agree.
- An accepted edge is a 0->1 transition of the stable register.
- The stable register is tracked in all modes; edges are acted on only in STEP.

LED path:
- ce_d = cpu_ce_o delayed one clock. The core's outputs change on the edge where ce is sampled.
- When ce_d=1: led_o <= led_i ^ {LED_N{LED_INV}}. Otherwise led_o holds.

Counter:
- ce_cnt_o increments on every cpu_ce_o=1 clock.
- Wraps 2^CNT_W-1 -> 0 silently.

Simultaneous events:
- A mode change and an enable condition in the same clock: the enable for the old mode still fires.
- Reset mid-pulse: cpu_ce_o is forced 0 immediately (async).

Timing: all outputs registered; no combinational path from inputs to outputs.

Test Plan:
- rst=0 for 3 clk, led_i=4'b1010, mode_i=00 -> during reset cpu_ce_o=0, led_o=0000, ce_cnt_o=0, mode_o=10; after release, first pulse 2 clocks after mode_o becomes 00 (div_i=1).
- RUN, div_i=3, 40 clocks -> pulses exactly every 4 clocks, ce_cnt_o=10 (±1 depending on phase); change div_i 3->0 mid-count (cnt=2) -> pulse next clock, then every clock.
- STEP, DEB_CYCLES=4 (override), button with 3-clock glitch then clean 10-clock press -> glitch ignored; exactly one pulse, 2 (sync) + 4 (debounce) + 1 clocks after the clean press; held button gives no second pulse; release and repress gives a second pulse.
- HALT or mode_i=11, with button pressed and div_i=0 -> cpu_ce_o stays 0 for 100 clocks; mode_o=10; ce_cnt_o unchanged.
- LED_INV=1, led_i=0110, run with div_i=2 -> led_o=1001 one clock after each pulse; led_i changes between pulses are not reflected until the next ce_d.
- Counter wrap with CNT_W=4, div_i=0 -> ce_cnt_o goes 15 -> 0. Async reset asserted mid-run while cpu_ce_o=1 -> cpu_ce_o=0 before the next clock edge.
